// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU MEM-stage port, the debug/loader port and the data_mem side
// of dmem_arbiter. The arbiter takes the slave modport; requesters and memory take master.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_o;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_addr, mem_data_i, mem_we,
        input  mem_data_o
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_addr, mem_data_i, mem_we,
        output mem_data_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the debug port.
// Default build arbitrates round-robin; define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority.
//
// state     | meaning
// ST_IDLE   | no access in flight; grant a requester and latch its request
// ST_ACCESS | memory busy; counter runs down the fixed read latency
// ST_DONE   | granted port completes (dbg_ack or cpu_stall release)
module dmem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int               CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_DBG} grant_e;

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              gnt_we_q, gnt_we_d;
    logic              mem_we_q, mem_we_d;
    logic              any_req;
    logic              pick_dbg;

    assign any_req = bus.cpu_req | bus.dbg_req;

`ifdef DMEM_ARB_CPU_PRIO_EN
    assign pick_dbg = ~bus.cpu_req;
`else
    // last_dbg_q = 1 means debug held the most recent grant, so the CPU wins the next tie.
    logic last_dbg_q;

    assign pick_dbg = bus.dbg_req & (~bus.cpu_req | ~last_dbg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dbg_q <= 1'b1;
        end else if (state_q == ST_IDLE && any_req) begin
            last_dbg_q <= pick_dbg;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        gnt_we_d    = gnt_we_q;
        mem_we_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_LOAD;
                    if (pick_dbg) begin
                        grant_d  = GNT_DBG;
                        addr_d   = bus.dbg_addr;
                        wdata_d  = bus.dbg_wdata;
                        gnt_we_d = bus.dbg_we;
                    end else begin
                        grant_d  = GNT_CPU;
                        addr_d   = bus.cpu_addr;
                        wdata_d  = bus.cpu_wdata;
                        gnt_we_d = bus.cpu_we;
                    end
                    // Strobe lands in the first ACCESS cycle only: one write per store.
                    mem_we_d = gnt_we_d;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                    if (!gnt_we_q) begin
                        if (grant_q == GNT_DBG) begin
                            dbg_rdata_d = bus.mem_data_o;
                        end else begin
                            cpu_rdata_d = bus.mem_data_o;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_NONE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            gnt_we_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            gnt_we_q    <= gnt_we_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_data_i = wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.dbg_ack    = (state_q == ST_DONE) && (grant_q == GNT_DBG);
    assign bus.cpu_stall  = bus.cpu_req & ~((state_q == ST_DONE) && (grant_q == GNT_CPU));

endmodule
